// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg
//   Shared definitions for the CPU-side RAM access controller.
//   Holds the default RAM geometry (128 x 16) and the controller FSM
//   state encoding, so that other blocks can decode the state if needed.
package cpu_mem_pkg;

  localparam int CPU_ADDR_W = 7;
  localparam int CPU_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RSP     = 2'd2,
    ST_CLEAR   = 2'd3
  } state_t;

endpackage

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//   Arbitrates CPU single-word reads/writes and a whole-RAM zero-fill onto
//   one synchronous single-port RAM (read data appears the cycle after
//   ram_read_en).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   CPU request handshake
//   req_we                1 = write, 0 = read
//   req_addr, req_wdata   request word address / write data
//   rsp_valid/rsp_ready   read response handshake
//   rsp_rdata             registered read data
//   wr_done               one-cycle pulse after each accepted write
//   clr_req / clr_done    zero-fill request / one-cycle completion pulse
//   busy                  FSM not idle
//   ram_*                 RAM port (enables are mutually exclusive)
module ram_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr_done,
  input  logic              clr_req,
  output logic              clr_done,
  output logic              busy,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              accept;
  logic              clr_last;

  assign accept   = req_valid && req_ready;
  assign clr_last = (state == ST_CLEAR) && (cnt == {ADDR_W{1'b1}});

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. clr_req wins over a request in IDLE and is
  // ignored everywhere else.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (clr_req)                 state_nxt = ST_CLEAR;
        else if (req_valid && !req_we) state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: state_nxt = ST_RSP;
      ST_RSP:     if (rsp_ready) state_nxt = ST_IDLE;
      ST_CLEAR:   if (clr_last)  state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output logic. Everything handshake- or RAM-facing is gated by rst_n so
  // nothing leaks out while reset is held, even with req_valid high.
  always_comb begin
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b0;
    ram_read_en  = 1'b0;
    ram_write_en = 1'b0;
    ram_addr     = req_addr;
    ram_din      = req_wdata;
    if (rst_n) begin
      unique case (state)
        ST_IDLE: begin
          req_ready = !clr_req;
          if (req_valid && !clr_req) begin
            ram_write_en = req_we;
            ram_read_en  = !req_we;
          end
        end
        ST_RD_WAIT: busy = 1'b1;
        ST_RSP: begin
          busy      = 1'b1;
          rsp_valid = 1'b1;
        end
        ST_CLEAR: begin
          busy         = 1'b1;
          ram_write_en = 1'b1;
          ram_addr     = cnt;
          ram_din      = '0;
        end
        default: ;
      endcase
    end
  end

  // Clear address counter: armed to 0 on entry, then walks every word.
  // It wraps back to 0 naturally after the last address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           cnt <= '0;
    else if (state == ST_IDLE && clr_req) cnt <= '0;
    else if (state == ST_CLEAR)           cnt <= cnt + 1'b1;
  end

  // Read data is captured once in RD_WAIT and then held for the whole
  // RSP phase, so it stays stable under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    rsp_rdata <= '0;
    else if (state == ST_RD_WAIT)  rsp_rdata <= ram_dout;
  end

  // Completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_done  <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      wr_done  <= accept && req_we;
      clr_done <= clr_last;
    end
  end

endmodule
